crc32_check: RTL and testbench
==============================

CRC32_CHECK -- requirements
Module: crc32_check

Interface
REQ-001 SHALL have parameter INIT, default 32'hFFFFFFFF, CRC register preset at each frame start.
REQ-002 SHALL have parameter XOROUT, default 32'hFFFFFFFF, value XORed onto the register before comparison/output.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port polynomial_i  input  32  reflected generator polynomial (e.g. 32'hEDB88320).
REQ-006 SHALL have port data_i  input  32  message word, or received CRC word when last_i=1.
REQ-007 SHALL have port valid_i  input  1  data_i/last_i valid.
REQ-008 SHALL have port last_i  input  1  current word is the received CRC and closes the frame.
REQ-009 SHALL have port ready_o  output  1  block accepts a word this cycle.
REQ-010 SHALL have port busy_o  output  1  frame in progress (first word accepted, done not yet issued).
REQ-011 SHALL have port done_o  output  1  one-cycle pulse: check result valid.
REQ-012 SHALL have port crc_ok_o  output  1  computed CRC equals received CRC; qualified by done_o, held until next done_o.
REQ-013 SHALL have port crc_o  output  32  computed CRC (register XOR XOROUT); held until next done_o.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, CHECK.
REQ-015 Handshake: word SHALL transfer only on a cycle with valid_i=1 and ready_o=1; ready_o=1 only in IDLE.
REQ-016 Data/last_i SHALL be ignored when ready_o=0; the source holds them until accepted.
REQ-017 On the first accepted word of a frame, the CRC register SHALL load INIT and polynomial_i SHALL be latched; polynomial_i changes mid-frame SHALL have no effect.
REQ-018 Accept with last_i=0 at cycle T: word latched, IDLE->SHIFT; bits 0..31 processed LSB-first, one per cycle, in cycles T+1..T+32; ready_o=1 again at T+33.
REQ-019 Per bit b: if (crc[0]^b) crc <= (crc>>1)^poly, else crc <= crc>>1.
REQ-020 Accept with last_i=1 at cycle T: data_i latched as received CRC, IDLE->CHECK; at T+1 done_o=1, crc_o=crc^XOROUT, crc_ok_o=(crc_o==received); state returns to IDLE, busy_o=0, ready_o=1 at T+2.
REQ-021 A frame consisting only of a last_i word SHALL compare INIT^XOROUT against data_i.
REQ-022 Back-to-back frames: the word accepted at T+2 after a CHECK SHALL start a new frame with INIT.
REQ-023 busy_o SHALL be 1 from the cycle after the first accept through the done_o cycle.
REQ-024 Bit counter SHALL be 5 bits and terminate SHIFT after exactly 32 bits, no wrap into a 33rd.

Reset
REQ-025 While rst_i=1 at a rising edge: state IDLE, CRC register=INIT, bit counter=0, ready_o=0, busy_o=0, done_o=0, crc_ok_o=0, crc_o=0.
REQ-026 ready_o SHALL rise in the first cycle after rst_i deasserts.
REQ-027 Reset asserted during SHIFT or CHECK SHALL abort the frame with no done_o pulse; the next frame starts clean.

Verification
REQ-028 Poly 32'hEDB88320, words 32'h00000000 (last=0) then 32'h2144DF1C (last=1) -> done_o one cycle, crc_o=32'h2144DF1C, crc_ok_o=1.
REQ-029 Same with CRC word 32'h2144DF1D -> crc_o=32'h2144DF1C, crc_ok_o=0.
REQ-030 Words 32'hFFFFFFFF then 32'hFFFFFFFF (last) -> crc_ok_o=1; ready_o low exactly 32 cycles after first accept.
REQ-031 valid_i held high with toggled data_i during SHIFT -> data ignored; result identical to REQ-028; polynomial_i changed mid-frame -> no effect.
REQ-032 rst_i pulsed at bit 16 of SHIFT -> no done_o; following REQ-028 frame passes.
REQ-033 Lone last_i word 32'h00000000 -> crc_o=0, crc_ok_o=1; next frame back-to-back passes.

Source files
------------

// File: rtl/crc32_check.sv
// ----------------------------------------------------------------------------
// crc32_check
// Serial, bit-per-cycle CRC-32 checker for word-framed messages.
// A frame is zero or more 32-bit message words followed by one word that
// carries the received CRC (flagged with last_i). Each message word is folded
// into the CRC register LSB-first, one bit per clock. The CRC word closes the
// frame and produces a one-cycle done_o pulse with the computed CRC and the
// pass/fail verdict.
//
// Parameters
//   INIT          CRC register preset at the first word of every frame
//   XOROUT        value XORed onto the register to form crc_o
//
// Ports
//   clk_i         clock, rising edge
//   rst_i         synchronous active-high reset
//   polynomial_i  reflected generator polynomial, latched at frame start
//   data_i        message word, or received CRC when last_i=1
//   valid_i       data_i/last_i valid
//   last_i        current word is the received CRC and closes the frame
//   ready_o       a word is accepted this cycle if valid_i=1
//   busy_o        frame in progress (first accept through done_o)
//   done_o        one-cycle pulse, crc_ok_o/crc_o valid
//   crc_ok_o      computed CRC equals received CRC, held until next done_o
//   crc_o         computed CRC (register ^ XOROUT), held until next done_o
// ----------------------------------------------------------------------------
module crc32_check #(
    parameter logic [31:0] INIT   = 32'hFFFF_FFFF,
    parameter logic [31:0] XOROUT = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] polynomial_i,
    input  logic [31:0] data_i,
    input  logic        valid_i,
    input  logic        last_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        crc_ok_o,
    output logic [31:0] crc_o
);

    localparam int unsigned CRC_W = 32;
    localparam int unsigned CNT_W = 5;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CRC_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t             state_q,   state_d;
    logic [CRC_W-1:0]   crc_q,     crc_d;
    logic [CRC_W-1:0]   poly_q,    poly_d;
    logic [CRC_W-1:0]   shreg_q,   shreg_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               ready_q,   ready_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               crc_ok_q,  crc_ok_d;
    logic [CRC_W-1:0]   crc_out_q, crc_out_d;

    // Combinational helpers
    logic               accept;
    logic               frame_start;
    logic [CRC_W-1:0]   base_crc;
    logic [CRC_W-1:0]   final_crc;
    logic               feedback;

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        poly_d    = poly_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        crc_ok_d  = crc_ok_q;
        crc_out_d = crc_out_q;

        accept      = valid_i && ready_q;
        // busy_q is low only between frames, so the next accept opens one
        frame_start = !busy_q;
        base_crc    = frame_start ? INIT : crc_q;
        final_crc   = base_crc ^ XOROUT;
        feedback    = crc_q[0] ^ shreg_q[0];

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    busy_d = 1'b1;
                    if (frame_start) begin
                        poly_d = polynomial_i;
                    end
                    crc_d = base_crc;
                    if (last_i) begin
                        // Verdict is registered here so it is visible in the CHECK cycle
                        crc_out_d = final_crc;
                        crc_ok_d  = (final_crc == data_i);
                        done_d    = 1'b1;
                        state_d   = CHECK;
                    end else begin
                        shreg_d = data_i;
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
                // One reflected LFSR step per cycle, message bit taken LSB-first
                if (feedback) begin
                    crc_d = (crc_q >> 1) ^ poly_q;
                end else begin
                    crc_d = crc_q >> 1;
                end
                shreg_d = shreg_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end

            CHECK: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // ready_o is registered, so it follows the state being entered
        ready_d = (state_d == IDLE);
    end

    // ------------------------------------------------------------------
    // Registers with synchronous reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            crc_q     <= INIT;
            poly_q    <= '0;
            shreg_q   <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            crc_ok_q  <= 1'b0;
            crc_out_q <= '0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            poly_q    <= poly_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            crc_ok_q  <= crc_ok_d;
            crc_out_q <= crc_out_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ready_o  = ready_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign crc_ok_o = crc_ok_q;
    assign crc_o    = crc_out_q;

endmodule

// File: tb/tb_crc32_check.sv
// ----------------------------------------------------------------------------
// tb_crc32_check
// Self-checking bench for crc32_check: directed frames with known CRC-32
// values, handshake/latency checks, mid-frame reset abort, and randomized
// frames checked against a word-queue reference model.
// ----------------------------------------------------------------------------
module tb_crc32_check;

    localparam logic [31:0] INIT   = 32'hFFFF_FFFF;
    localparam logic [31:0] XOROUT = 32'hFFFF_FFFF;
    localparam logic [31:0] POLY   = 32'hEDB8_8320;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] polynomial_i;
    logic [31:0] data_i;
    logic        valid_i;
    logic        last_i;
    logic        ready_o;
    logic        busy_o;
    logic        done_o;
    logic        crc_ok_o;
    logic [31:0] crc_o;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [31:0] msg_q[$];

    always #5 clk = ~clk;

    crc32_check #(
        .INIT   (INIT),
        .XOROUT (XOROUT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .polynomial_i (polynomial_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .last_i       (last_i),
        .ready_o      (ready_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .crc_ok_o     (crc_ok_o),
        .crc_o        (crc_o)
    );

    // Count every done pulse so aborted frames can be shown to produce none
    always @(negedge clk) begin
        if (done_o === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: standard reflected CRC over the queued words, LSB of each word first
    function automatic logic [31:0] model_crc(input logic [31:0] poly);
        logic [31:0] c;
        c = INIT;
        foreach (msg_q[i]) begin
            for (int b = 0; b < 32; b++) begin
                if (c[0] ^ msg_q[i][b]) c = (c >> 1) ^ poly;
                else                    c = c >> 1;
            end
        end
        return c ^ XOROUT;
    endfunction

    // Offer one word until accepted; for message words, count the cycles ready_o stays low
    task automatic send_word(input logic [31:0] data, input logic last, input bit noisy,
                             output int low_cycles);
        int          wait_n;
        logic [31:0] poly_keep;
        wait_n    = 0;
        poly_keep = polynomial_i;
        data_i    = data;
        last_i    = last;
        valid_i   = 1'b1;
        while (ready_o !== 1'b1 && wait_n < 200) begin
            step();
            wait_n++;
        end
        if (ready_o !== 1'b1) check_eq("ready_timeout", 32'(ready_o), 32'd1);
        step();
        valid_i    = 1'b0;
        last_i     = 1'b0;
        low_cycles = 0;
        if (!last) begin
            while (ready_o !== 1'b1 && low_cycles < 100) begin
                if (noisy) begin
                    valid_i      = 1'b1;
                    data_i       = $urandom;
                    last_i       = 1'($urandom_range(0, 1));
                    polynomial_i = $urandom;
                end
                step();
                low_cycles++;
            end
            valid_i      = 1'b0;
            last_i       = 1'b0;
            polynomial_i = poly_keep;
        end
    endtask

    // Send msg_q followed by crc_word and check the verdict and handshake timing
    task automatic run_frame(input logic [31:0] poly, input logic [31:0] crc_word,
                             input bit noisy, input string tag);
        logic [31:0] exp;
        int          low;
        exp          = model_crc(poly);
        polynomial_i = poly;
        foreach (msg_q[i]) begin
            send_word(msg_q[i], 1'b0, noisy, low);
            check_eq({tag, "_rdy_low"}, 32'(low), 32'd32);
        end
        send_word(crc_word, 1'b1, 1'b0, low);
        check_eq({tag, "_done"},   32'(done_o),   32'd1);
        check_eq({tag, "_crc"},    crc_o,         exp);
        check_eq({tag, "_ok"},     32'(crc_ok_o), 32'(exp == crc_word));
        check_eq({tag, "_busy"},   32'(busy_o),   32'd1);
        step();
        check_eq({tag, "_done_1"}, 32'(done_o),   32'd0);
        check_eq({tag, "_ready"},  32'(ready_o),  32'd1);
        check_eq({tag, "_idle"},   32'(busy_o),   32'd0);
        check_eq({tag, "_hold"},   crc_o,         exp);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_ready"}, 32'(ready_o),  32'd0);
        check_eq({tag, "_busy"},  32'(busy_o),   32'd0);
        check_eq({tag, "_done"},  32'(done_o),   32'd0);
        check_eq({tag, "_ok"},    32'(crc_ok_o), 32'd0);
        check_eq({tag, "_crc"},   crc_o,         32'd0);
    endtask

    initial begin
        int          d0;
        int          n;
        logic [31:0] poly;
        logic [31:0] exp;
        logic [31:0] crcw;
        bit          noisy;

        rst_i        = 1'b1;
        polynomial_i = POLY;
        data_i       = '0;
        valid_i      = 1'b0;
        last_i       = 1'b0;

        // Reset state, then ready_o rises in the first cycle out of reset
        step();
        step();
        check_reset_state("rst");
        rst_i = 1'b0;
        step();
        check_eq("rst_rel_ready", 32'(ready_o), 32'd1);
        check_eq("rst_rel_busy",  32'(busy_o),  32'd0);

        // CRC-32 of four zero bytes, correct CRC word
        msg_q = {32'h0000_0000};
        run_frame(POLY, 32'h2144_DF1C, 1'b0, "zero_ok");
        check_eq("zero_ok_lit",  crc_o,         32'h2144_DF1C);
        check_eq("zero_ok_flag", 32'(crc_ok_o), 32'd1);

        // Same frame with a corrupted CRC word
        run_frame(POLY, 32'h2144_DF1D, 1'b0, "zero_bad");
        check_eq("zero_bad_lit",  crc_o,         32'h2144_DF1C);
        check_eq("zero_bad_flag", 32'(crc_ok_o), 32'd0);

        // All-ones word: CRC-32 of FF FF FF FF is FFFFFFFF
        msg_q = {32'hFFFF_FFFF};
        run_frame(POLY, 32'hFFFF_FFFF, 1'b0, "ones");
        check_eq("ones_flag", 32'(crc_ok_o), 32'd1);

        // Inputs toggled while the block is shifting, polynomial changed mid-frame
        msg_q = {32'h0000_0000};
        run_frame(POLY, 32'h2144_DF1C, 1'b1, "noisy");
        check_eq("noisy_lit",  crc_o,         32'h2144_DF1C);
        check_eq("noisy_flag", 32'(crc_ok_o), 32'd1);

        // Reset at bit 16 of SHIFT aborts the frame without a done pulse
        d0      = done_cnt;
        data_i  = 32'h0000_0000;
        last_i  = 1'b0;
        valid_i = 1'b1;
        n       = 0;
        while (ready_o !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        step();
        valid_i = 1'b0;
        check_eq("abort_busy", 32'(busy_o), 32'd1);
        repeat (16) step();
        rst_i = 1'b1;
        step();
        check_reset_state("abort_rst");
        rst_i = 1'b0;
        repeat (40) step();
        check_eq("abort_no_done", 32'(done_cnt), 32'(d0));
        msg_q = {32'h0000_0000};
        run_frame(POLY, 32'h2144_DF1C, 1'b0, "post_abort");
        check_eq("post_abort_flag", 32'(crc_ok_o), 32'd1);

        // Lone CRC word, then a back-to-back frame
        msg_q.delete();
        run_frame(POLY, 32'h0000_0000, 1'b0, "lone");
        check_eq("lone_lit",  crc_o,         32'h0000_0000);
        check_eq("lone_flag", 32'(crc_ok_o), 32'd1);
        msg_q = {32'h0000_0000};
        run_frame(POLY, 32'h2144_DF1C, 1'b0, "b2b");
        check_eq("b2b_flag", 32'(crc_ok_o), 32'd1);

        // Randomized frames: random length, polynomial, data, and CRC corruption
        for (int f = 0; f < 24; f++) begin
            msg_q.delete();
            n = $urandom_range(0, 3);
            for (int w = 0; w < n; w++) msg_q.push_back($urandom);
            poly  = $urandom;
            exp   = model_crc(poly);
            crcw  = ($urandom_range(0, 1) == 1) ? exp : (exp ^ (32'h1 << $urandom_range(0, 31)));
            noisy = 1'($urandom_range(0, 1));
            run_frame(poly, crcw, noisy, $sformatf("rnd%0d", f));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
